alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one MIPSALU instance among NREQ requesters. Each requester presents an ALU control code and two operands under a valid/ready handshake. The arbiter grants one request at a time, registers the operands, drives the external ALU for one cycle, and captures ALUOut/Zero. It then returns the result, tagged with the requester index, over a single response channel. It sits between issuing units (decode/execute slots) and the shared MIPSALU.

---
 rtl/alu_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational MIPS ALU among NREQ requesters.
// One op in flight: IDLE grants and loads the ALU inputs, EXEC captures the result, RESP presents it.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_ctl,
    input  logic [W*NREQ-1:0]    req_a,
    input  logic [W*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [3:0]           alu_ctl,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    input  logic [W-1:0]         alu_out,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  op_id_q;
    logic            err_q;
    logic [3:0]      alu_ctl_q;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W-1:0]    rsp_data_q;
    logic            rsp_zero_q;
    logic            rsp_err_q;

    logic [IDW-1:0]  grant;
    logic            grant_vld;
    logic            take;
    int              gi;

    function automatic logic ctl_illegal(input logic [3:0] c);
        case (c)
            4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: return 1'b0;
            default:                             return 1'b1;
        endcase
    endfunction

    // Scan downward in distance so the nearest requester after last_grant_q wins.
    always_comb begin
        grant     = last_grant_q;
        grant_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant_q) + k) % NREQ]) begin
                grant     = IDW'((int'(last_grant_q) + k) % NREQ);
                grant_vld = 1'b1;
            end
        end
    end

    assign take = (state_q == IDLE) && grant_vld;
    assign gi   = int'(grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so no accept strobe can leak out while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        if (take && rst_n) begin
            req_ready = NREQ'(1) << grant;
        end
        if (state_q == RESP) begin
            rsp_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(NREQ - 1);
            op_id_q      <= '0;
            err_q        <= 1'b0;
            alu_ctl_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (take) begin
                last_grant_q <= grant;
                op_id_q      <= grant;
                alu_ctl_q    <= req_ctl[4*gi +: 4];
                alu_a_q      <= req_a[W*gi +: W];
                alu_b_q      <= req_b[W*gi +: W];
                err_q        <= ctl_illegal(req_ctl[4*gi +: 4]);
            end
            if (state_q == EXEC) begin
                rsp_id_q   <= op_id_q;
                rsp_data_q <= alu_out;
                rsp_zero_q <= alu_zero;
                rsp_err_q  <= err_q;
            end
        end
    end

    assign alu_ctl  = alu_ctl_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a combinational MIPS ALU model, a per-cycle reference model of the
// round-robin sequencer, directed literal checks, then randomized traffic with resets.
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [4*NREQ-1:0]   req_ctl = '0;
    logic [W*NREQ-1:0]   req_a = '0;
    logic [W*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]     req_ready;
    logic [3:0]          alu_ctl;
    logic [W-1:0]        alu_a, alu_b, alu_out;
    logic                alu_zero;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_data;
    logic                rsp_zero, rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [NREQ-1:0] acc_mask = '0;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
    assign alu_zero = (alu_out == '0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle/busy with an age counter, the remembered op and last grant.
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_last = NREQ - 1;
    int          m_id = 0;
    logic [3:0]  m_ctl = '0;
    logic [W-1:0] m_a = '0, m_b = '0;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        logic [W-1:0]    exp_data;
        int              g;
        if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_last = NREQ - 1;
            m_ctl = '0; m_a = '0; m_b = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_zero_err", {rsp_zero, rsp_err}, 0);
            chk("rst_alu", {alu_ctl, alu_a, alu_b}, 0);
            acc_mask = '0;
        end else begin
            exp_ready = '0;
            g = -1;
            if (!m_busy) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("rsp_valid", rsp_valid, m_busy && m_age >= 2);
            chk("alu_inputs", {alu_ctl, alu_a, alu_b}, {m_ctl, m_a, m_b});
            if (m_busy && m_age >= 2) begin
                exp_data = alu_fn(m_ctl, m_a, m_b);
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_data", rsp_data, exp_data);
                chk("rsp_zero", rsp_zero, exp_data == '0);
                chk("rsp_err", rsp_err, !(m_ctl inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12}));
            end
            acc_mask = req_valid & req_ready;
            if (g >= 0) begin
                m_busy = 1'b1; m_age = 1; m_last = g; m_id = g;
                m_ctl = req_ctl[4*g +: 4]; m_a = req_a[W*g +: W]; m_b = req_b[W*g +: W];
            end else if (m_busy && m_age == 1) begin
                m_age = 2;
            end else if (m_busy && rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask;
    endtask

    task automatic set_req(input int i, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        req_ctl[4*i +: 4] = c;
        req_a[W*i +: W]   = a;
        req_b[W*i +: W]   = b;
        req_valid[i]      = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_op();
        if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 3));
        return $urandom();
    endfunction

    logic [3:0]   fctl[4] = '{4'd2, 4'd6, 4'd0, 4'd1};
    logic [W-1:0] fexp[4] = '{32'd21, 32'd12, 32'd0, 32'd23};
    logic [3:0]   ctls[9] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd5, 4'd15};

    initial begin
        // Reset held with all requesters asking: nothing may be accepted.
        #1 rst_n = 1'b0;
        req_valid = '1;
        #1;
        chk("lit_rst_ready", req_ready, 0);
        chk("lit_rst_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #1 req_valid = '0;
        rst_n = 1'b1;

        // Single add
        set_req(0, 4'd2, 32'd5, 32'd7);
        #1 chk("lit_single_ready", req_ready, 4'b0001);
        step();
        chk("lit_single_exec_ready", req_ready, 0);
        step();
        chk("lit_single_valid", rsp_valid, 1);
        chk("lit_single_data", rsp_data, 12);
        chk("lit_single_id", rsp_id, 0);
        chk("lit_single_zero_err", {rsp_zero, rsp_err}, 0);
        step();

        // Fairness from a fresh reset: grants 0,1,2,3,0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, fctl[i], W'(16 + i), 32'd5);
        for (int k = 0; k < 5; k++) begin
            #1 chk("lit_fair_grant", req_ready, 4'b0001 << (k % 4));
            step(); req_valid = '1;
            step(); req_valid = '1;
            chk("lit_fair_id", rsp_id, k % 4);
            chk("lit_fair_data", rsp_data, fexp[k % 4]);
            step(); req_valid = '1;
        end
        req_valid = '0;

        // Zero / compare
        set_req(0, 4'd6, 32'h1234, 32'h1234);
        step(); step();
        chk("lit_sub_data", rsp_data, 0);
        chk("lit_sub_zero", rsp_zero, 1);
        step();
        set_req(0, 4'd7, 32'd3, 32'd9);
        step(); step();
        chk("lit_slt_data", rsp_data, 1);
        chk("lit_slt_zero", rsp_zero, 0);
        step();

        // Backpressure with requester 1 waiting
        rsp_ready = 1'b0;
        set_req(3, 4'd2, 32'd10, 32'd20);
        #1 chk("lit_bp_grant3", req_ready, 4'b1000);
        step();
        set_req(1, 4'd2, 32'd1, 32'd1);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("lit_bp_valid", rsp_valid, 1);
            chk("lit_bp_data", rsp_data, 30);
            chk("lit_bp_id", rsp_id, 3);
            chk("lit_bp_ready", req_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1 chk("lit_bp_ready_same", req_ready, 0);
        step();
        chk("lit_bp_grant1", req_ready, 4'b0010);
        step(); step();
        chk("lit_bp_id1", rsp_id, 1);
        chk("lit_bp_data1", rsp_data, 2);
        step();

        // Illegal control code
        set_req(2, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(); step();
        chk("lit_ill_data", rsp_data, 0);
        chk("lit_ill_zero", rsp_zero, 1);
        chk("lit_ill_err", rsp_err, 1);
        step();

        // Reset during EXEC, then reset during RESP
        set_req(1, 4'd2, 32'd4, 32'd4);
        step();
        rst_n = 1'b0;
        #1;
        chk("lit_rexec_valid", rsp_valid, 0);
        chk("lit_rexec_alu_a", alu_a, 0);
        step();
        rst_n = 1'b1;
        set_req(2, 4'd1, 32'd8, 32'd1);
        set_req(0, 4'd2, 32'd1, 32'd2);
        #1 chk("lit_rexec_first0", req_ready, 4'b0001);
        step(); step();
        chk("lit_rexec_id0", rsp_id, 0);
        chk("lit_rexec_data0", rsp_data, 3);
        step();
        chk("lit_rexec_then2", req_ready, 4'b0100);
        step(); step();
        chk("lit_rresp_valid_pre", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("lit_rresp_valid", rsp_valid, 0);
        chk("lit_rresp_data", rsp_data, 0);
        step();
        rst_n = 1'b1;

        // Randomized traffic, backpressure and occasional resets
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                #1 rst_n = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        logic [W-1:0] a;
                        a = rand_op();
                        set_req(i, ctls[$urandom_range(0, 8)], a, ($urandom_range(0, 3) == 0) ? a : rand_op());
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
